// File: rtl/dec_correction_ctrl.sv
// Single-bit correction sequencer: classifies an incoming word, drives the
// bit-flip unit for one cycle, then holds the result until downstream takes it.
module dec_correction_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_codeword,
  input  logic [4:0]            in_error_col,
  input  logic                  in_syn_nonzero,
  input  logic                  in_parity_err,
  output logic [DATA_WIDTH-1:0] flip_codeword,
  output logic [4:0]            flip_col,
  input  logic [DATA_WIDTH-1:0] flip_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            num_of_errors,
  output logic [CNT_WIDTH-1:0]  single_cnt,
  output logic [CNT_WIDTH-1:0]  double_cnt,
  input  logic                  cnt_clear
);

  typedef enum logic [1:0] {
    IDLE,
    CORRECT,
    OUT
  } state_t;

  state_t state, nstate;

  logic [1:0] cls_q, cls_d;
  logic       fix_q;
  logic       col_ok;
  logic       accept;

  assign col_ok = {1'b0, in_error_col} < 6'(DATA_WIDTH);
  assign accept = (state == IDLE) && in_valid;

  always_comb begin
    cls_d = 2'd0;
    if (in_parity_err)
      cls_d = 2'd1;
    else if (in_syn_nonzero)
      cls_d = 2'd2;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = CORRECT;
      end
      CORRECT: nstate = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // The flip-unit drive doubles as the captured word, so it only moves on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_codeword <= '0;
      flip_col      <= '0;
      cls_q         <= '0;
      fix_q         <= 1'b0;
    end else if (accept) begin
      flip_codeword <= in_codeword;
      flip_col      <= in_error_col;
      cls_q         <= cls_d;
      fix_q         <= in_parity_err & in_syn_nonzero & col_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data      <= '0;
      num_of_errors <= '0;
    end else if (state == CORRECT) begin
      out_data      <= fix_q ? flip_data : flip_codeword;
      num_of_errors <= cls_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (cnt_clear) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (state == CORRECT) begin
      if (cls_q == 2'd1 && single_cnt != '1)
        single_cnt <= single_cnt + CNT_WIDTH'(1);
      if (cls_q == 2'd2 && double_cnt != '1)
        double_cnt <= double_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
